// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running hcount/vcount with registered de,
// hsync, vsync, line/frame start pulses and an en-gated delay line that
// produces hsync_d/vsync_d/de_d aligned to a registered pixel pipeline.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        de_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject geometries the 12-bit counters or the delay line cannot represent.
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("video_timing_gen: porch and sync widths must be non-zero");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("video_timing_gen: PIPE_DLY must be 0..7");
  end

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q, vcount_d;
  logic        active_q, active_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Next raster position: advance one pixel per enabled cycle, wrap line and frame together.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 12'd1;
      end else begin
        hcount_d = hcount_q + 12'd1;
      end
    end
  end

  // Decode from the next position so registered flags line up with the registered counters.
  always_comb begin
    active_d      = (hcount_d < H_ACT_W) && (vcount_d < V_ACT_W);
    hs_d          = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_d          = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? VS_POL : ~VS_POL;
    // Pulses only on an enabled edge, so a stall never stretches them.
    line_start_d  = en && (hcount_d == '0);
    frame_start_d = line_start_d && (vcount_d == '0);
  end

  // Raster state registers; reset parks on the last blanking pixel so the first step lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      active_q      <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      active_q      <= active_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign de          = active_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

  if (PIPE_DLY == 0) begin : g_no_dly
    assign hsync_d = hs_q;
    assign vsync_d = vs_q;
    assign de_d    = active_q;
  end else begin : g_dly
    typedef struct packed {
      logic hs;
      logic vs;
      logic de;
    } tap_t;

    localparam tap_t TAP_RST = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    tap_t [PIPE_DLY-1:0] pipe_q, pipe_d;

    // Shift register that moves only on enabled cycles, matching the pixel pipeline stall.
    always_comb begin
      pipe_d = pipe_q;
      if (en) begin
        pipe_d[0] = '{hs: hs_q, vs: vs_q, de: active_q};
        for (int i = 1; i < PIPE_DLY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    // Delay stages; NOTE: these are reset because downstream sync must be inactive until real data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_q <= {PIPE_DLY{TAP_RST}};
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign hsync_d = pipe_q[PIPE_DLY-1].hs;
    assign vsync_d = pipe_q[PIPE_DLY-1].vs;
    assign de_d    = pipe_q[PIPE_DLY-1].de;
  end

endmodule
